// File: rtl/lcd_seq_pkg.sv
// lcd_seq_pkg: shared types and constants for the LCD stream sequencer.
package lcd_seq_pkg;
  typedef enum logic [1:0] {ENT_CMD, ENT_DATA, ENT_DELAY, ENT_END} ent_t;
  typedef struct packed {
    ent_t       kind;
    logic [7:0] val;
  } rom_entry_t;
  typedef enum logic [3:0] {
    ST_RST_LOW, ST_RST_WAIT, ST_FETCH, ST_SEND, ST_WAIT_MS,
    ST_WIN, ST_PIX_GET, ST_PIX_HI, ST_PIX_LO
  } state_t;
  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;
  localparam logic [15:0] BAR_RED   = 16'hF800;
  localparam logic [15:0] BAR_GREEN = 16'h07E0;
  localparam logic [15:0] BAR_BLUE  = 16'h001F;
  localparam logic [15:0] BAR_WHITE = 16'hFFFF;
endpackage

// File: rtl/lcd_seq_init_rom.sv
// lcd_init_rom: ST7789 init table, registered case ROM (one cycle latency).
module lcd_init_rom
  import lcd_seq_pkg::*;
(
  input  logic       clk,
  input  logic [3:0] i_addr,
  output rom_entry_t o_entry
);
  always_ff @(posedge clk)
    case (i_addr)
      4'd0:    o_entry <= '{ENT_CMD,   8'h01};
      4'd1:    o_entry <= '{ENT_DELAY, 8'd150};
      4'd2:    o_entry <= '{ENT_CMD,   8'h11};
      4'd3:    o_entry <= '{ENT_DELAY, 8'd120};
      4'd4:    o_entry <= '{ENT_CMD,   8'h3A};
      4'd5:    o_entry <= '{ENT_DATA,  8'h55};
      4'd6:    o_entry <= '{ENT_CMD,   8'h36};
      4'd7:    o_entry <= '{ENT_DATA,  8'h00};
      4'd8:    o_entry <= '{ENT_CMD,   8'h21};
      4'd9:    o_entry <= '{ENT_CMD,   8'h13};
      4'd10:   o_entry <= '{ENT_CMD,   8'h29};
      4'd11:   o_entry <= '{ENT_DELAY, 8'd20};
      default: o_entry <= '{ENT_END,   8'h00};
    endcase
endmodule

// File: rtl/lcd_stream_sequencer.sv
// lcd_stream_sequencer: LCD reset, ROM init playback, then endless window + RGB565 pixel streaming.
// Optional colour-bar source enabled by LCD_STREAM_SEQUENCER_TESTPATTERN_EN.
module lcd_stream_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 27_000_000,
  parameter int WIDTH         = 135,
  parameter int HEIGHT        = 240,
  parameter int X_OFFSET      = 52,
  parameter int Y_OFFSET      = 40,
  parameter int RESET_LOW_MS  = 10,
  parameter int RESET_WAIT_MS = 120
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        lcd_resetn,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_byte,
  output logic        tx_dc,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [15:0] pix_data,
  input  logic        test_mode,
  output logic        init_done,
  output logic        frame_start
);
  localparam int MS_CYC = CLK_FREQ_HZ / 1000;
  localparam int PW = MS_CYC > 1 ? $clog2(MS_CYC) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(MS_CYC - 1);
  localparam logic [15:0] NPIX_M1 = 16'(WIDTH * HEIGHT - 1);
  localparam logic [87:0] WIN_SEQ = {CMD_CASET, 16'(X_OFFSET), 16'(X_OFFSET + WIDTH - 1),
                                     CMD_RASET, 16'(Y_OFFSET), 16'(Y_OFFSET + HEIGHT - 1), CMD_RAMWR};
  state_t      r_state, w_state_n;
  logic [3:0]  r_idx, w_idx_n, r_win;
  logic [PW-1:0] r_pre;
  logic [7:0]  r_ms, w_dly_n;
  logic [15:0] r_pix, r_pix_cnt, w_pix_n;
  logic [87:0] w_win_shift;
  logic        r_init_done, w_xfer, w_tick, w_dly_act, w_dly_done, w_pix_take, w_frame_end;
  rom_entry_t  w_ent;
  // ROM is addressed with the next index so its registered output is valid in FETCH
  lcd_init_rom u_rom (.clk(clk), .i_addr(w_idx_n), .o_entry(w_ent));
  assign w_xfer      = tx_valid && tx_ready;
  assign w_tick      = r_pre == PRE_MAX;
  assign w_dly_act   = r_state inside {ST_RST_LOW, ST_RST_WAIT, ST_WAIT_MS};
  assign w_dly_n     = r_state == ST_RST_LOW ? 8'(RESET_LOW_MS) :
                       r_state == ST_RST_WAIT ? 8'(RESET_WAIT_MS) : w_ent.val;
  assign w_dly_done  = w_dly_n == 8'd0 || (w_tick && r_ms == w_dly_n - 8'd1);
  assign w_frame_end = r_pix_cnt == NPIX_M1;
  assign w_win_shift = WIN_SEQ << {r_win, 3'b000};
`ifdef LCD_STREAM_SEQUENCER_TESTPATTERN_EN
  logic [15:0] r_col, w_bar_pix;
  logic [17:0] w_bar_pos;
  assign w_bar_pos  = {r_col, 2'b00} / 18'(WIDTH);
  assign w_bar_pix  = w_bar_pos == 18'd0 ? BAR_RED : w_bar_pos == 18'd1 ? BAR_GREEN :
                      w_bar_pos == 18'd2 ? BAR_BLUE : BAR_WHITE;
  assign w_pix_take = r_state == ST_PIX_GET && (test_mode || pix_valid);
  assign w_pix_n    = test_mode ? w_bar_pix : pix_data;
  assign pix_ready  = r_state == ST_PIX_GET && !test_mode;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_col <= '0;
    else if (w_pix_take) r_col <= (r_col == 16'(WIDTH - 1) || w_frame_end) ? '0 : r_col + 16'd1;
`else
  logic w_unused_test_mode;
  assign w_unused_test_mode = test_mode;
  assign w_pix_take = r_state == ST_PIX_GET && pix_valid;
  assign w_pix_n    = pix_data;
  assign pix_ready  = r_state == ST_PIX_GET;
`endif
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_state <= ST_RST_LOW;
    else r_state <= w_state_n;
  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    case (r_state)
      ST_RST_LOW:  if (w_dly_done) w_state_n = ST_RST_WAIT;
      ST_RST_WAIT: if (w_dly_done) w_state_n = ST_FETCH;
      ST_FETCH:    w_state_n = w_ent.kind == ENT_DELAY ? ST_WAIT_MS :
                               w_ent.kind == ENT_END ? ST_WIN : ST_SEND;
      ST_SEND:     if (w_xfer) begin
        w_state_n = ST_FETCH;
        w_idx_n   = r_idx + 4'd1;
      end
      ST_WAIT_MS:  if (w_dly_done) begin
        w_state_n = ST_FETCH;
        w_idx_n   = r_idx + 4'd1;
      end
      ST_WIN:      if (w_xfer && r_win == 4'd10) w_state_n = ST_PIX_GET;
      ST_PIX_GET:  if (w_pix_take) w_state_n = ST_PIX_HI;
      ST_PIX_HI:   if (w_xfer) w_state_n = ST_PIX_LO;
      ST_PIX_LO:   if (w_xfer) w_state_n = w_frame_end ? ST_WIN : ST_PIX_GET;
      default:     w_state_n = ST_RST_LOW;
    endcase
  end
  always_comb begin
    lcd_resetn  = r_state != ST_RST_LOW;
    tx_valid    = r_state inside {ST_SEND, ST_WIN, ST_PIX_HI, ST_PIX_LO};
    tx_dc       = r_state == ST_SEND ? w_ent.kind == ENT_DATA :
                  r_state == ST_WIN ? !(r_win == 4'd0 || r_win == 4'd5 || r_win == 4'd10) : tx_valid;
    tx_byte     = r_state == ST_SEND ? w_ent.val : r_state == ST_WIN ? w_win_shift[87:80] :
                  r_state == ST_PIX_HI ? r_pix[15:8] : r_state == ST_PIX_LO ? r_pix[7:0] : 8'h00;
    frame_start = r_state == ST_WIN && r_win == 4'd10 && tx_ready;
    init_done   = r_init_done;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_idx       <= '0;
      r_pre       <= '0;
      r_ms        <= '0;
      r_win       <= '0;
      r_pix       <= '0;
      r_pix_cnt   <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_idx       <= w_idx_n;
      r_pre       <= (!w_dly_act || w_dly_done || w_tick) ? '0 : r_pre + 1'b1;
      r_ms        <= (!w_dly_act || w_dly_done) ? 8'd0 : w_tick ? r_ms + 8'd1 : r_ms;
      r_init_done <= r_init_done || (r_state == ST_FETCH && w_ent.kind == ENT_END);
      if (r_state == ST_WIN && w_xfer) r_win <= r_win == 4'd10 ? 4'd0 : r_win + 4'd1;
      if (w_pix_take) r_pix <= w_pix_n;
      if (r_state == ST_PIX_LO && w_xfer) r_pix_cnt <= w_frame_end ? 16'd0 : r_pix_cnt + 16'd1;
    end
endmodule

// File: tb/tb_lcd_stream_sequencer.sv
// tb_lcd_stream_sequencer: table-driven byte-log check of init, window and pixel streaming on a 4x2 frame.
module tb_lcd_stream_sequencer;
  logic clk = 1'b0, resetn = 1'b1, tx_ready = 1'b0, pix_valid = 1'b0, test_mode = 1'b0;
  logic lcd_resetn, tx_valid, tx_dc, pix_ready, init_done, frame_start;
  logic [7:0] tx_byte;
  logic [15:0] pix_data;
  int errors = 0, checks = 0, pix_taken = 0;
  logic [15:0] pix_tab [8] = '{16'hA5C3, 16'h1234, 16'h0001, 16'hFFFF,
                               16'h8000, 16'h00FF, 16'h5A5A, 16'hC0DE};
  logic [7:0] win_tab [11] = '{8'h2A, 8'h00, 8'h34, 8'h00, 8'h37,
                               8'h2B, 8'h00, 8'h28, 8'h00, 8'h29, 8'h2C};
  typedef struct {
    logic [7:0] b;
    logic       dc;
    int         lo;
    int         hi;
    logic       idn;
    logic       fs;
  } vec_t;
  vec_t vt[$];
  lcd_stream_sequencer #(
    .CLK_FREQ_HZ(1000), .WIDTH(4), .HEIGHT(2), .X_OFFSET(52), .Y_OFFSET(40),
    .RESET_LOW_MS(10), .RESET_WAIT_MS(120)
  ) dut (
    .clk(clk), .resetn(resetn), .lcd_resetn(lcd_resetn), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_byte(tx_byte), .tx_dc(tx_dc), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_data(pix_data), .test_mode(test_mode),
    .init_done(init_done), .frame_start(frame_start)
  );
  always #5 clk = ~clk;
  assign pix_data = pix_tab[3'(pix_taken)];
  always @(posedge clk) if (pix_valid && pix_ready) pix_taken <= pix_taken + 1;
  always @(negedge clk) if (resetn) begin
    checks++;
    if (pix_ready && tx_valid) begin
      errors++;
      $display("FAIL ready_excl: pix_ready=1 while tx_valid=1 at %0t", $time);
    end
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic chk_rng(input string n, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", n, act, lo, hi);
    end
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_lcd_resetn"}, 32'(lcd_resetn), 0);
    chk({tag, "_tx_valid"}, 32'(tx_valid), 0);
    chk({tag, "_tx_byte"}, 32'(tx_byte), 0);
    chk({tag, "_tx_dc"}, 32'(tx_dc), 0);
    chk({tag, "_pix_ready"}, 32'(pix_ready), 0);
    chk({tag, "_init_done"}, 32'(init_done), 0);
    chk({tag, "_frame_start"}, 32'(frame_start), 0);
  endtask
  task automatic startup(input string tag);
    int n;
    n = 0;
    while (!lcd_resetn && n < 100) begin n++; @(negedge clk); end
    chk_rng({tag, "_rst_low_cycles"}, n, 9, 11);
    n = 0;
    while (!tx_valid && n < 1000) begin n++; @(negedge clk); end
    chk_rng({tag, "_rst_wait_cycles"}, n, 119, 123);
    chk({tag, "_first_byte"}, 32'(tx_byte), 32'h01);
    chk({tag, "_first_dc"}, 32'(tx_dc), 0);
  endtask
  function automatic vec_t v(logic [7:0] b, logic dc, int lo, int hi, logic idn, logic fs);
    vec_t r;
    r.b = b; r.dc = dc; r.lo = lo; r.hi = hi; r.idn = idn; r.fs = fs;
    return r;
  endfunction
  initial begin
    int n, s;
    vt.push_back(v(8'h01, 0, 0, 0, 0, 0));
    vt.push_back(v(8'h11, 0, 150, 154, 0, 0));
    vt.push_back(v(8'h3A, 0, 120, 124, 0, 0));
    vt.push_back(v(8'h55, 1, 0, 3, 0, 0));
    vt.push_back(v(8'h36, 0, 0, 3, 0, 0));
    vt.push_back(v(8'h00, 1, 0, 3, 0, 0));
    vt.push_back(v(8'h21, 0, 0, 3, 0, 0));
    vt.push_back(v(8'h13, 0, 0, 3, 0, 0));
    vt.push_back(v(8'h29, 0, 0, 3, 0, 0));
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 11; k++)
        vt.push_back(v(win_tab[k], !(k == 0 || k == 5 || k == 10),
                       (f == 0 && k == 0) ? 20 : 0, (f == 0 && k == 0) ? 24 : 2, 1, k == 10));
      if (f == 0)
        for (int p = 0; p < 8; p++) begin
          vt.push_back(v(pix_tab[p][15:8], 1, 0, 3, 1, 0));
          vt.push_back(v(pix_tab[p][7:0], 1, 0, 2, 1, 0));
        end
    end
    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    pix_valid = 1'b1;
    resetn = 1'b1;
    startup("boot");
    foreach (vt[i]) begin
      tx_ready = 1'b0;
      n = 0;
      while (!tx_valid && n < 1000) begin @(negedge clk); n++; end
      chk_rng($sformatf("gap%0d", i), n, vt[i].lo, vt[i].hi);
      s = $urandom_range(0, 1) != 0 ? int'($urandom_range(1, 3)) : 0;
      repeat (s) begin
        chk($sformatf("stall_valid%0d", i), 32'(tx_valid), 1);
        chk($sformatf("stall_byte%0d", i), 32'(tx_byte), 32'(vt[i].b));
        chk($sformatf("stall_dc%0d", i), 32'(tx_dc), 32'(vt[i].dc));
        @(negedge clk);
      end
      chk($sformatf("byte%0d", i), 32'(tx_byte), 32'(vt[i].b));
      chk($sformatf("dc%0d", i), 32'(tx_dc), 32'(vt[i].dc));
      chk($sformatf("init_done%0d", i), 32'(init_done), 32'(vt[i].idn));
      tx_ready = 1'b1;
      #1 chk($sformatf("frame_start%0d", i), 32'(frame_start), 32'(vt[i].fs));
      @(negedge clk);
    end
    tx_ready = 1'b0;
    chk("pixels_per_frame", 32'(pix_taken), 8);
    pix_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("stall_no_tx", 32'(tx_valid), 0);
    chk("stall_pix_ready", 32'(pix_ready), 1);
    chk("stall_no_take", 32'(pix_taken), 8);
    pix_valid = 1'b1;
    tx_ready = 1'b1;
    n = 0;
    while (!tx_valid && n < 100) begin @(negedge clk); n++; end
    tx_ready = 1'b0;
    @(negedge clk);
    chk("wrap_pix_hi", 32'(tx_byte), 32'hA5);
    chk("wrap_valid", 32'(tx_valid), 1);
    #2 resetn = 1'b0;
    #1 chk_reset_vals("midreset");
    @(negedge clk);
    chk_reset_vals("midreset_hold");
    resetn = 1'b1;
    startup("reboot");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
